// File: rtl/immediate_unit.sv
// immediate_unit: formats instruction immediates into a DATA_W result behind a single valid/ready output register.
// Define IMMEDIATE_UNIT_BRANCH_TARGET_EN to also register pc_plus4 + branch offset on out_branch_target.
module immediate_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned JUMP_W = 26,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        mode,
  input  logic [IMM_W-1:0]  raw_imm,
  input  logic [JUMP_W-1:0] jump_idx,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_branch_target,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_count
);

  typedef enum logic [2:0] {
    MODE_ZEXT   = 3'd0,
    MODE_SEXT   = 3'd1,
    MODE_UPPER  = 3'd2,
    MODE_BRANCH = 3'd3,
    MODE_JUMP   = 3'd4,
    MODE_SHAMT  = 3'd5,
    MODE_ILL6   = 3'd6,
    MODE_ILL7   = 3'd7
  } mode_e;

  mode_e                     mode_sel;
  logic                      xfer;
  logic                      load;
  logic signed [IMM_W-1:0]   raw_s;
  logic signed [DATA_W-1:0]  sext;
  logic        [DATA_W-1:0]  jmask;
  logic        [DATA_W-1:0]  fmt_imm;
  logic                      fmt_err;

  logic                      valid_q, valid_d;
  logic        [DATA_W-1:0]  imm_q, imm_d;
  logic                      err_q, err_d;
  logic        [CNT_W-1:0]   cnt_q, cnt_d;

  assign mode_sel = mode_e'(mode);
  assign in_ready = !valid_q || out_ready;
  assign xfer     = in_valid && in_ready;
  assign load     = xfer && !flush;
  assign raw_s    = raw_imm;
  assign sext     = raw_s;
  // Mask form of {pc_plus4[DATA_W-1:JUMP_W+2], jump_idx, 2'b00}; stays legal when JUMP_W+2 == DATA_W.
  assign jmask    = DATA_W'({(JUMP_W+2){1'b1}});

  always_comb begin
    fmt_imm = '0;
    fmt_err = 1'b0;
    case (mode_sel)
      MODE_ZEXT:   fmt_imm = DATA_W'(raw_imm);
      MODE_SEXT:   fmt_imm = sext;
      MODE_UPPER:  fmt_imm = DATA_W'(raw_imm) << (DATA_W - IMM_W);
      MODE_BRANCH: fmt_imm = sext << 2;
      MODE_JUMP:   fmt_imm = (pc_plus4 & ~jmask) | (DATA_W'(jump_idx) << 2);
      MODE_SHAMT:  fmt_imm = DATA_W'(raw_imm[10:6]);
      default:     fmt_err = 1'b1;
    endcase
  end

  always_comb begin
    valid_d = valid_q;
    imm_d   = imm_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (xfer) begin
      valid_d = 1'b1;
      imm_d   = fmt_imm;
      err_d   = fmt_err;
      if (fmt_err && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    end else if (out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      imm_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      imm_q   <= imm_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef IMMEDIATE_UNIT_BRANCH_TARGET_EN
  logic [DATA_W-1:0] tgt_q, tgt_d;

  always_comb begin
    tgt_d = tgt_q;
    if (load) tgt_d = (mode_sel == MODE_BRANCH) ? (pc_plus4 + (sext << 2)) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tgt_q <= '0;
    else     tgt_q <= tgt_d;
  end

  assign out_branch_target = tgt_q;
`else
  logic unused_load;
  assign unused_load       = load;
  assign out_branch_target = '0;
`endif

  assign out_valid = valid_q;
  assign out_imm   = imm_q;
  assign out_err   = err_q;
  assign err_count = cnt_q;

endmodule

// File: tb/tb_immediate_unit.sv
// Self-checking bench for immediate_unit: directed vector table, stall/flush/reset sequences, random scoreboard run.
module tb_immediate_unit;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IMM_W  = 16;
  localparam int unsigned JUMP_W = 26;
  localparam int unsigned CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        mode;
  logic [IMM_W-1:0]  raw_imm;
  logic [JUMP_W-1:0] jump_idx;
  logic [DATA_W-1:0] pc_plus4;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_imm;
  logic [DATA_W-1:0] out_branch_target;
  logic              out_err;
  logic [CNT_W-1:0]  err_count;

  int checks = 0;
  int errors = 0;

  immediate_unit #(.DATA_W(DATA_W), .IMM_W(IMM_W), .JUMP_W(JUMP_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .raw_imm(raw_imm), .jump_idx(jump_idx), .pc_plus4(pc_plus4), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_branch_target(out_branch_target), .out_err(out_err), .err_count(err_count)
  );

  always #5 clk = ~clk;

`ifdef IMMEDIATE_UNIT_BRANCH_TARGET_EN
  localparam bit TGT_EN = 1'b1;
`else
  localparam bit TGT_EN = 1'b0;
`endif

  // Reference model: plain arithmetic on integers.
  function automatic longint sval(input logic [IMM_W-1:0] r);
    longint v = longint'(r);
    if (v >= 32768) v = v - 65536;
    return v;
  endfunction

  function automatic logic [DATA_W-1:0] ref_imm(input logic [2:0] m, input logic [IMM_W-1:0] r,
                                                input logic [JUMP_W-1:0] j, input logic [DATA_W-1:0] pc);
    longint v;
    case (m)
      3'd0: v = longint'(r);
      3'd1: v = sval(r);
      3'd2: v = longint'(r) * 65536;
      3'd3: v = sval(r) * 4;
      3'd4: v = (longint'(pc) / 268435456) * 268435456 + longint'(j) * 4;
      3'd5: v = (longint'(r) / 64) % 32;
      default: v = 0;
    endcase
    return DATA_W'(v);
  endfunction

  function automatic logic [DATA_W-1:0] ref_tgt(input logic [2:0] m, input logic [IMM_W-1:0] r,
                                                input logic [DATA_W-1:0] pc);
    if (!TGT_EN || m != 3'd3) return '0;
    return DATA_W'(longint'(pc) + sval(r) * 4);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]        m;
    logic [IMM_W-1:0]  r;
    logic [JUMP_W-1:0] j;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] e_imm;
    logic [DATA_W-1:0] e_tgt;
    logic              e_err;
  } vec_t;

  vec_t vecs[8];
  int   exp_cnt;
  logic [DATA_W-1:0] held_imm, held_tgt;
  logic              held_err;

  // Scoreboard state for the random phase
  logic              s_valid, s_err;
  logic [DATA_W-1:0] s_imm, s_tgt;

  initial begin
    rst = 1'b1; in_valid = 0; mode = 0; raw_imm = 0; jump_idx = 0; pc_plus4 = 0;
    flush = 0; out_ready = 0;
    exp_cnt = 0;

    vecs[0] = '{3'd1, 16'hFFFC, '0, 32'h0, 32'hFFFFFFFC, 32'h0, 1'b0};
    vecs[1] = '{3'd2, 16'h1234, '0, 32'h0, 32'h12340000, 32'h0, 1'b0};
    vecs[2] = '{3'd3, 16'hFFFF, '0, 32'h00400010, 32'hFFFFFFFC, TGT_EN ? 32'h0040000C : 32'h0, 1'b0};
    vecs[3] = '{3'd4, 16'h0, 26'h0000010, 32'hA0000004, 32'hA0000040, 32'h0, 1'b0};
    vecs[4] = '{3'd5, 16'h07C0, '0, 32'h0, 32'h0000001F, 32'h0, 1'b0};
    vecs[5] = '{3'd0, 16'h8001, '0, 32'h0, 32'h00008001, 32'h0, 1'b0};
    vecs[6] = '{3'd6, 16'hABCD, '0, 32'h0, 32'h0, 32'h0, 1'b1};
    vecs[7] = '{3'd7, 16'h1111, '0, 32'h0, 32'h0, 32'h0, 1'b1};

    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_imm", out_imm, 0);
    check("rst_out_tgt", out_branch_target, 0);
    check("rst_out_err", out_err, 0);
    check("rst_err_count", err_count, 0);
    check("rst_in_ready", in_ready, 1);
    step(); step();
    rst = 1'b0;
    step();

    // Directed table
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; mode = vecs[i].m; raw_imm = vecs[i].r; jump_idx = vecs[i].j; pc_plus4 = vecs[i].pc;
      step();
      in_valid = 0;
      if (vecs[i].e_err) exp_cnt++;
      check($sformatf("vec%0d_valid", i), out_valid, 1);
      check($sformatf("vec%0d_imm", i), out_imm, vecs[i].e_imm);
      check($sformatf("vec%0d_tgt", i), out_branch_target, vecs[i].e_tgt);
      check($sformatf("vec%0d_err", i), out_err, vecs[i].e_err);
      check($sformatf("vec%0d_cnt", i), err_count, exp_cnt);
      step();
      check($sformatf("vec%0d_drain", i), out_valid, 0);
    end

    // Stall: hold out_ready low for 3 cycles, then accept and load with no bubble
    out_ready = 0; in_valid = 1; mode = 3'd3; raw_imm = 16'h0010; pc_plus4 = 32'h1000;
    step();
    held_imm = out_imm; held_tgt = out_branch_target; held_err = out_err;
    check("stall_first_imm", held_imm, 32'h40);
    mode = 3'd0; raw_imm = 16'h5555;
    for (int c = 0; c < 3; c++) begin
      step();
      check("stall_valid", out_valid, 1);
      check("stall_imm", out_imm, held_imm);
      check("stall_tgt", out_branch_target, held_tgt);
      check("stall_err", out_err, held_err);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1;
    #1 check("stall_release_in_ready", in_ready, 1);
    step();
    check("nobubble_valid", out_valid, 1);
    check("nobubble_imm", out_imm, 32'h5555);
    in_valid = 0;
    step();

    // Flush with a same-cycle illegal request: discarded, count unaffected
    in_valid = 1; mode = 3'd6; flush = 1;
    step();
    flush = 0; in_valid = 0;
    check("flush_valid", out_valid, 0);
    check("flush_cnt", err_count, exp_cnt);

    // 300 back-to-back illegal requests saturate the counter
    in_valid = 1; mode = 3'd6; out_ready = 1;
    for (int k = 0; k < 300; k++) begin
      step();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
      check("sat_valid", out_valid, 1);
      check("sat_err", out_err, 1);
      check("sat_cnt", err_count, exp_cnt);
    end
    in_valid = 0;
    step();

    // Random run against the scoreboard
    s_valid = 0; s_err = 0; s_imm = '0; s_tgt = '0;
    for (int n = 0; n < 400; n++) begin
      logic xf;
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(2) != 0);
      flush     = ($urandom_range(15) == 0);
      mode      = 3'($urandom_range(7));
      raw_imm   = 16'($urandom);
      jump_idx  = 26'($urandom);
      pc_plus4  = $urandom;
      #1;
      check("rnd_in_ready", in_ready, (!s_valid || out_ready));
      xf = in_valid && (!s_valid || out_ready);
      if (flush) s_valid = 0;
      else if (xf) begin
        s_valid = 1;
        s_imm = ref_imm(mode, raw_imm, jump_idx, pc_plus4);
        s_tgt = ref_tgt(mode, raw_imm, pc_plus4);
        s_err = (mode >= 3'd6);
        if (s_err && exp_cnt < 255) exp_cnt++;
      end else if (out_ready) s_valid = 0;
      step();
      check("rnd_valid", out_valid, s_valid);
      check("rnd_cnt", err_count, exp_cnt);
      if (s_valid) begin
        check("rnd_imm", out_imm, s_imm);
        check("rnd_tgt", out_branch_target, s_tgt);
        check("rnd_err", out_err, s_err);
      end
    end
    flush = 0;

    // Reset asserted mid-stall, away from any clock edge
    out_ready = 0; in_valid = 1; mode = 3'd7;
    step();
    in_valid = 0; mode = 3'd1; raw_imm = 16'h8000;
    step();
    check("prerst_valid", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_cnt", err_count, 0);
    check("async_rst_imm", out_imm, 0);
    check("async_rst_err", out_err, 0);
    step();
    rst = 1'b0;
    #1 check("post_rst_in_ready", in_ready, 1);
    step();
    check("post_rst_in_ready_cycle", in_ready, 1);
    check("post_rst_valid", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
